// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU: op codes, FSM states, op-class helpers.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL   = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'd8;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'd9;
  localparam logic [OP_W-1:0] ALU_MUL   = 4'd10;
  localparam logic [OP_W-1:0] ALU_MULHU = 4'd11;
  localparam logic [OP_W-1:0] ALU_DIV   = 4'd12;
  localparam logic [OP_W-1:0] ALU_DIVU  = 4'd13;
  localparam logic [OP_W-1:0] ALU_REM   = 4'd14;
  localparam logic [OP_W-1:0] ALU_REMU  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Multi-cycle ops: MUL, MULHU and the four divide/remainder ops
  function automatic logic is_md(input logic [OP_W-1:0] op);
    return op >= ALU_MUL;
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return op >= ALU_DIV;
  endfunction

  function automatic logic is_sdiv(input logic [OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiplier (shift-add) and restoring divider sharing one operand/accumulator set.
// done_c/result_c reflect the final step combinationally so the caller can register them directly.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            active_q;
  logic [CW-1:0]   count_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            is_mul_c;
  logic [XLEN:0]   sum_c;
  logic [XLEN:0]   rsh_c;
  logic [XLEN-1:0] diff_c;
  logic            ge_c;
  logic [XLEN-1:0] hi_d;
  logic [XLEN-1:0] lo_d;

  assign is_mul_c = (op_q == ALU_MUL) || (op_q == ALU_MULHU);

  // One iteration: hi/lo act as {acc, multiplier} for mul, {remainder, quotient} for div
  always_comb begin
    sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
    rsh_c  = {hi_q, lo_q[XLEN-1]};
    diff_c = rsh_c[XLEN-1:0] - opnd_q;
    ge_c   = (rsh_c >= {1'b0, opnd_q});
    if (is_mul_c) begin
      hi_d = sum_c[XLEN:1];
      lo_d = {sum_c[0], lo_q[XLEN-1:1]};
    end else begin
      hi_d = ge_c ? diff_c : rsh_c[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge_c};
    end
  end

  assign done_c = active_q && (count_q == CW'(XLEN-1));

  // Result selection with sign fix-up applied to the last step's values
  always_comb begin
    result_c = '0;
    case (op_q)
      ALU_MUL:   result_c = lo_d;
      ALU_MULHU: result_c = hi_d;
      ALU_DIV:   result_c = neg_quo_q ? (~lo_d + XLEN'(1)) : lo_d;
      ALU_DIVU:  result_c = lo_d;
      ALU_REM:   result_c = neg_rem_q ? (~hi_d + XLEN'(1)) : hi_d;
      ALU_REMU:  result_c = hi_d;
      default:   result_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      count_q   <= '0;
      op_q      <= ALU_MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      active_q <= 1'b0;
      count_q  <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      count_q  <= '0;
      op_q     <= op;
      hi_q     <= '0;
      if (is_sdiv(op)) begin
        lo_q      <= a[XLEN-1] ? (~a + XLEN'(1)) : a;
        opnd_q    <= b[XLEN-1] ? (~b + XLEN'(1)) : b;
        neg_quo_q <= a[XLEN-1] ^ b[XLEN-1];
        neg_rem_q <= a[XLEN-1];
      end else begin
        lo_q      <= a;
        opnd_q    <= b;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end
    end else if (active_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (done_c) begin
        active_q <= 1'b0;
        count_q  <= '0;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked execute-stage ALU: single-cycle RV32I ops, iterative RV32M mul/div.
// Holds the accept/busy/done FSM, the single-cycle datapath and divide corner-case resolution.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          MD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] result_d;
  logic            out_valid_d;
  logic [XLEN-1:0] simple_c;
  logic [SHW-1:0]  shamt_c;
  logic            md_start_c;
  logic            md_done_c;
  logic [XLEN-1:0] md_result_c;

  assign shamt_c = op_b[SHW-1:0];

  // Single-cycle datapath; mul/div codes fall to zero (used directly when MD_EN=0)
  always_comb begin
    simple_c = '0;
    case (op)
      ALU_ADD:  simple_c = op_a + op_b;
      ALU_SUB:  simple_c = op_a - op_b;
      ALU_AND:  simple_c = op_a & op_b;
      ALU_OR:   simple_c = op_a | op_b;
      ALU_XOR:  simple_c = op_a ^ op_b;
      ALU_SLL:  simple_c = op_a << shamt_c;
      ALU_SRL:  simple_c = op_a >> shamt_c;
      ALU_SRA:  simple_c = $unsigned($signed(op_a) >>> shamt_c);
      ALU_SLT:  simple_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: simple_c = XLEN'(op_a < op_b);
      default:  simple_c = '0;
    endcase
  end

  generate
    if (MD_EN) begin : g_md
      alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (md_start_c),
        .op       (op),
        .a        (op_a),
        .b        (op_b),
        .done_c   (md_done_c),
        .result_c (md_result_c)
      );
    end else begin : g_no_md
      assign md_done_c   = 1'b0;
      assign md_result_c = '0;
    end
  endgenerate

  // Next-state and output logic; flush overrides everything, including a same-cycle accept
  always_comb begin
    state_d     = state_q;
    result_d    = result;
    out_valid_d = out_valid;
    md_start_c  = 1'b0;
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (MD_EN && is_md(op)) begin
              if (is_div(op) && (op_b == '0)) begin
                result_d    = ((op == ALU_DIV) || (op == ALU_DIVU)) ? '1 : op_a;
                state_d     = S_DONE;
                out_valid_d = 1'b1;
              end else if (is_sdiv(op) && (op_a == MIN_NEG) && (op_b == '1)) begin
                result_d    = (op == ALU_DIV) ? op_a : '0;
                state_d     = S_DONE;
                out_valid_d = 1'b1;
              end else begin
                md_start_c = 1'b1;
                state_d    = S_BUSY;
              end
            end else begin
              result_d    = simple_c;
              state_d     = S_DONE;
              out_valid_d = 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (md_done_c) begin
            result_d    = md_result_c;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      result    <= result_d;
      out_valid <= out_valid_d;
      in_ready  <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (XLEN=32, MD_EN=1).
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_iter #(.XLEN(32), .MD_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Present one op for a single accept edge, then scramble the operand inputs
  task automatic accept(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'd1; op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D;
  endtask

  // Cycles from accept until out_valid is seen (1 = visible right after the accept edge)
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h exp 00000000", result); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", busy); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_simple;
    logic [3:0]  vo [10];
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] ve [10];
    int lat;
    vo = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4};
    va = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000,
           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    vb = '{32'h1, 32'h1, 32'h4, 32'h1, 32'h1, 32'd33, 32'h4, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
    ve = '{32'h0, 32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h0, 32'h2, 32'h08000000,
           32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0};
    for (int i = 0; i < 10; i++) begin
      accept(vo[i], va[i], vb[i]);
      wait_out(lat);
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL simple[%0d] latency: got %0d exp 1", i, lat); end
      n_checks++; if (result !== ve[i]) begin n_fail++; $display("FAIL simple[%0d] op %0d result: got %h exp %h", i, vo[i], result, ve[i]); end
      consume();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL simple[%0d] out_valid after ready: got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_muldiv;
    logic [3:0]  vo [10];
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] ve [10];
    int lat;
    vo = '{4'd10, 4'd11, 4'd12, 4'd14, 4'd13, 4'd15, 4'd12, 4'd14, 4'd11, 4'd10};
    va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFFD};
    vb = '{32'h2, 32'h2, 32'h2, 32'h2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5};
    ve = '{32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'h1,
           32'hFFFFFFFE, 32'hFFFFFFF1};
    for (int i = 0; i < 10; i++) begin
      accept(vo[i], va[i], vb[i]);
      wait_out(lat);
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL muldiv[%0d] latency: got %0d exp 33", i, lat); end
      n_checks++; if (result !== ve[i]) begin n_fail++; $display("FAIL muldiv[%0d] op %0d result: got %h exp %h", i, vo[i], result, ve[i]); end
      consume();
    end
  endtask

  task automatic test_div_corner;
    logic [3:0]  vo [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    int lat;
    vo = '{4'd13, 4'd15, 4'd12, 4'd14, 4'd12, 4'd14};
    va = '{32'd5, 32'd5, 32'd5, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    vb = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ve = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      accept(vo[i], va[i], vb[i]);
      wait_out(lat);
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL divcorner[%0d] latency: got %0d exp 1", i, lat); end
      n_checks++; if (result !== ve[i]) begin n_fail++; $display("FAIL divcorner[%0d] result: got %h exp %h", i, result, ve[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    accept(4'd0, 32'd3, 32'd4);
    wait_out(lat);
    op = 4'd0; op_a = 32'd100; op_b = 32'd100; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] out_valid: got %b exp 1", i, out_valid); end
      n_checks++; if (result !== 32'd7) begin n_fail++; $display("FAIL hold[%0d] result: got %h exp 00000007", i, result); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] in_ready: got %b exp 0", i, in_ready); end
    end
    in_valid = 1'b0;
    consume();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold release out_valid: got %b exp 0", out_valid); end
    n_checks++; if (result !== 32'd7) begin n_fail++; $display("FAIL hold release result: got %h exp 00000007", result); end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    op = 4'd0; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_v = (i % 2 == 0);
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL b2b[%0d] out_valid: got %b exp %b", i, out_valid, exp_v); end
      n_checks++; if (in_ready !== !exp_v) begin n_fail++; $display("FAIL b2b[%0d] in_ready: got %b exp %b", i, in_ready, !exp_v); end
    end
    n_checks++; if (result !== 32'd3) begin n_fail++; $display("FAIL b2b result: got %h exp 00000003", result); end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    int seen;
    int lat;
    prev = result;
    accept(4'd13, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 4'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush busy: got %b exp 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush in_ready: got %b exp 1", in_ready); end
    n_checks++; if (result !== prev) begin n_fail++; $display("FAIL flush result: got %h exp %h", result, prev); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush out_valid cycles: got %0d exp 0", seen); end
    // flush beats a same-cycle accept
    op = 4'd0; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush-vs-accept busy: got %b exp 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush-vs-accept out_valid: got %b exp 0", out_valid); end
    // flush drops a held result but keeps the register value
    accept(4'd0, 32'd10, 32'd20);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush-done out_valid: got %b exp 0", out_valid); end
    n_checks++; if (result !== 32'd30) begin n_fail++; $display("FAIL flush-done result: got %h exp 0000001e", result); end
    accept(4'd10, 32'd3, 32'd5);
    wait_out(lat);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL post-flush mul latency: got %0d exp 33", lat); end
    n_checks++; if (result !== 32'd15) begin n_fail++; $display("FAIL post-flush mul result: got %h exp 0000000f", result); end
    consume();
  endtask

  task automatic test_reset_mid_mul;
    int lat;
    accept(4'd10, 32'hFFFFFFFF, 32'h2);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b exp 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midrst result: got %h exp 00000000", result); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready: got %b exp 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b exp 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    accept(4'd10, 32'd3, 32'd5);
    wait_out(lat);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL post-rst mul latency: got %0d exp 33", lat); end
    n_checks++; if (result !== 32'd15) begin n_fail++; $display("FAIL post-rst mul result: got %h exp 0000000f", result); end
    consume();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; op_a = 32'h0; op_b = 32'h0;
    test_reset();
    test_simple();
    test_muldiv();
    test_div_corner();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
